// File: rtl/gc_pkg.sv
// ---------------------------------------------------------------------------
// gc_pkg
// Definitions shared by the Global Controller blocks: the program-block
// sequencer, the IC-signal one-hot mux and the comparator matrix.
//
// Contents:
//   MAX_NO_OF_PROGRAM_BLOCKS_DEFAULT  default number of program-block slots
//   DUR_WIDTH_DEFAULT                 default width of a per-block duration
//   PB_IDX_WIDTH_DEFAULT              default width of block index / count
//   REPEAT_WIDTH                      width of the optional repeat count
//   pb_seq_state_t                    sequencer state encoding
// ---------------------------------------------------------------------------
package gc_pkg;

    localparam int MAX_NO_OF_PROGRAM_BLOCKS_DEFAULT = 12;
    localparam int DUR_WIDTH_DEFAULT                = 16;
    localparam int PB_IDX_WIDTH_DEFAULT             = 4;
    localparam int REPEAT_WIDTH                     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pb_seq_state_t;

endpackage : gc_pkg

// File: rtl/pb_select_sequencer_if.sv
// ---------------------------------------------------------------------------
// pb_select_sequencer_if
// Control / status bundle between the controller FSM (master) and the
// program-block select sequencer (slave).
//
// Signals:
//   start, abort, advance   controller -> sequencer commands
//   cfg_num_pb              number of active program blocks
//   cfg_duration            flattened durations, block k at [k*DUR_WIDTH +: DUR_WIDTH]
//   cfg_repeat              extra passes over the block list (PB_SEQ_REPEAT_EN only)
//   pb_sel                  one-hot program-block select toward the IC mux
//   pb_idx                  binary index of the active block
//   busy, done              sequencer status
//
// Build option: define PB_SEQ_REPEAT_EN to add cfg_repeat.
// ---------------------------------------------------------------------------
interface pb_select_sequencer_if
    import gc_pkg::*;
#(
    parameter int MAX_NO_OF_PROGRAM_BLOCKS = MAX_NO_OF_PROGRAM_BLOCKS_DEFAULT,
    parameter int DUR_WIDTH                = DUR_WIDTH_DEFAULT,
    parameter int PB_IDX_WIDTH             = PB_IDX_WIDTH_DEFAULT
);

    logic                                          start;
    logic                                          abort;
    logic                                          advance;
    logic [PB_IDX_WIDTH-1:0]                       cfg_num_pb;
    logic [MAX_NO_OF_PROGRAM_BLOCKS*DUR_WIDTH-1:0] cfg_duration;
`ifdef PB_SEQ_REPEAT_EN
    logic [REPEAT_WIDTH-1:0]                       cfg_repeat;
`endif
    logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]           pb_sel;
    logic [PB_IDX_WIDTH-1:0]                       pb_idx;
    logic                                          busy;
    logic                                          done;

    modport master (
        output start, abort, advance, cfg_num_pb, cfg_duration,
`ifdef PB_SEQ_REPEAT_EN
        output cfg_repeat,
`endif
        input  pb_sel, pb_idx, busy, done
    );

    modport slave (
        input  start, abort, advance, cfg_num_pb, cfg_duration,
`ifdef PB_SEQ_REPEAT_EN
        input  cfg_repeat,
`endif
        output pb_sel, pb_idx, busy, done
    );

endinterface : pb_select_sequencer_if

// File: rtl/pb_duration_counter.sv
// ---------------------------------------------------------------------------
// pb_duration_counter
// Loadable down-counter holding the remaining advance steps of the active
// program block. Load wins over decrement; decrement stops at zero.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load load_value on the next rising edge
//   load_value   new count
//   dec          decrement by one on the next rising edge
//   value        current count
//   zero         value == 0
// ---------------------------------------------------------------------------
module pb_duration_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - WIDTH'(1);
        end
    end

    assign zero = (value == '0);

endmodule : pb_duration_counter

// File: rtl/pb_select_sequencer.sv
// ---------------------------------------------------------------------------
// pb_select_sequencer
// Walks the configured program blocks 0..N-1 and drives the one-hot select
// of the Global Controller's IC-signal mux. Each block stays selected for
// duration+1 advance-high cycles. All outputs are registered.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   pb_select_sequencer_if.slave: start/abort/advance, configuration,
//         pb_sel/pb_idx/busy/done
//
// Build option: PB_SEQ_REPEAT_EN adds cfg_repeat; the whole block list is
// then executed cfg_repeat+1 times back to back before done.
// ---------------------------------------------------------------------------
module pb_select_sequencer
    import gc_pkg::*;
#(
    parameter int MAX_NO_OF_PROGRAM_BLOCKS = MAX_NO_OF_PROGRAM_BLOCKS_DEFAULT,
    parameter int DUR_WIDTH                = DUR_WIDTH_DEFAULT,
    parameter int PB_IDX_WIDTH             = PB_IDX_WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    pb_select_sequencer_if.slave  bus
);

    localparam logic [PB_IDX_WIDTH-1:0] MAX_NUM  = PB_IDX_WIDTH'(MAX_NO_OF_PROGRAM_BLOCKS);
    localparam logic [PB_IDX_WIDTH:0]   IDX_ONE  = (PB_IDX_WIDTH+1)'(1);

    pb_seq_state_t                       state_q, state_d;
    logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] sel_q, sel_d;
    logic [PB_IDX_WIDTH-1:0]             idx_q, idx_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;

    logic [PB_IDX_WIDTH-1:0]             neff;
    logic                                last_block;
    logic                                repeat_more;

    logic                                cnt_load;
    logic                                cnt_dec;
    logic [PB_IDX_WIDTH-1:0]             load_idx;
    logic [DUR_WIDTH-1:0]                cnt_load_value;
    logic [DUR_WIDTH-1:0]                cnt_value;
    logic                                cnt_zero;

`ifdef PB_SEQ_REPEAT_EN
    logic [REPEAT_WIDTH-1:0]             rep_q, rep_d;
    assign repeat_more = (rep_q != '0);
`else
    assign repeat_more = 1'b0;
`endif

    // Block count is clamped to the slot count, never wrapped.
    assign neff = (bus.cfg_num_pb > MAX_NUM) ? MAX_NUM : bus.cfg_num_pb;

    // Widened by one bit so idx+1 cannot overflow before the compare.
    assign last_block = (({1'b0, idx_q} + IDX_ONE) >= {1'b0, neff});

    // Duration of the block about to be loaded.
    always_comb begin
        cnt_load_value = '0;
        for (int k = 0; k < MAX_NO_OF_PROGRAM_BLOCKS; k++) begin
            if (load_idx == PB_IDX_WIDTH'(k)) begin
                cnt_load_value = bus.cfg_duration[k*DUR_WIDTH +: DUR_WIDTH];
            end
        end
    end

    pb_duration_counter #(
        .WIDTH      (DUR_WIDTH)
    ) u_duration_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PB_SEQ_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PB_SEQ_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Next-state logic; abort overrides everything.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.start) state_d = (neff == '0) ? ST_DONE : ST_RUN;
                ST_RUN:  if (bus.advance && cnt_zero && last_block && !repeat_more)
                             state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the counter controls.
    always_comb begin
        sel_d    = sel_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = (state_d == ST_DONE);
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        load_idx = '0;
`ifdef PB_SEQ_REPEAT_EN
        rep_d    = rep_q;
`endif
        if (bus.abort) begin
            sel_d  = '0;
            idx_d  = '0;
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
`ifdef PB_SEQ_REPEAT_EN
                        rep_d = bus.cfg_repeat;
`endif
                        if (neff != '0) begin
                            idx_d    = '0;
                            sel_d    = MAX_NO_OF_PROGRAM_BLOCKS'(1);
                            busy_d   = 1'b1;
                            cnt_load = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.advance) begin
                        cnt_dec = (cnt_value != '0);
                        if (cnt_zero) begin
                            if (!last_block) begin
                                idx_d    = idx_q + PB_IDX_WIDTH'(1);
                                sel_d    = sel_q << 1;
                                cnt_load = 1'b1;
                                load_idx = idx_q + PB_IDX_WIDTH'(1);
                            end else if (repeat_more) begin
                                // Wrap to block 0 with no idle cycle in between.
`ifdef PB_SEQ_REPEAT_EN
                                rep_d    = rep_q - REPEAT_WIDTH'(1);
`endif
                                idx_d    = '0;
                                sel_d    = MAX_NO_OF_PROGRAM_BLOCKS'(1);
                                cnt_load = 1'b1;
                            end else begin
                                idx_d    = '0;
                                sel_d    = '0;
                                busy_d   = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pb_sel = sel_q;
    assign bus.pb_idx = idx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule : pb_select_sequencer
